// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the 5-stage RISC-V core: owns the PC and the IF/ID register,
// and reports the IF/ID instruction's source registers to the hazard unit.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcWriteEnable,
   input  logic        if_kill,
   input  logic        exe_isBranchOrJumpTaken,
   input  logic [31:0] exe_branchTarget,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data,
   input  logic        imem_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        if_valid,
   output logic [4:0]  if_rs1Address,
   output logic [4:0]  if_rs2Address
);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // The per-edge update decision; one value per row of the priority chain.
   typedef enum logic [2:0] {
      ACT_RESET,
      ACT_REDIRECT,
      ACT_STALL,
      ACT_FLUSH,
      ACT_WAIT,
      ACT_FETCH
   } fetch_action_t;

   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic [31:0]   ifid_pc_q;
   logic [31:0]   ifid_pc_d;
   logic [31:0]   ifid_instr_q;
   logic [31:0]   ifid_instr_d;
   logic          ifid_valid_q;
   logic          ifid_valid_d;
   logic [31:0]   pc_plus4;
   logic [31:0]   redirect_pc;
   fetch_action_t action;

   assign pc_plus4    = pc_q + 32'd4;
   assign redirect_pc = {exe_branchTarget[31:2], 2'b00};

   // imem handshake: imem_address is always a request; imem_data is consumed
   // only on an edge where imem_ready=1 and the stage actually advances.
   always_comb begin
      action = ACT_FETCH;
      if (rst)
         action = ACT_RESET;
      else if (exe_isBranchOrJumpTaken)
         action = ACT_REDIRECT;
      else if (!pcWriteEnable)
         action = ACT_STALL;
      else if (if_kill)
         action = ACT_FLUSH;
      else if (!imem_ready)
         action = ACT_WAIT;
   end

   always_comb begin
      pc_d         = pc_q;
      ifid_pc_d    = 32'd0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      unique case (action)
         ACT_RESET: begin
            pc_d = RESET_PC;
         end
         ACT_REDIRECT: begin
            pc_d = redirect_pc;
         end
         ACT_STALL: begin
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_valid_d = ifid_valid_q;
         end
         ACT_FLUSH: begin
            pc_d = pc_plus4;
         end
         ACT_WAIT: begin
            pc_d = pc_q;
         end
         ACT_FETCH: begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_data;
            ifid_valid_d = 1'b1;
         end
         default: begin
            pc_d = pc_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
   end

   assign imem_address   = pc_q;
   assign if_pc          = ifid_pc_q;
   assign if_instruction = ifid_instr_q;
   assign if_valid       = ifid_valid_q;

   // Driven from IF/ID only, so the hazard unit sees no loop through its own outputs.
   logic [6:0] opcode;
   logic       uses_rs1;
   logic       uses_rs2;

   assign opcode = ifid_instr_q[6:0];

   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         OP_REG, OP_STORE, OP_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            uses_rs1 = 1'b1;
         end
         default: begin
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
         end
      endcase
   end

   assign if_rs1Address = (ifid_valid_q && uses_rs1) ? ifid_instr_q[19:15] : 5'd0;
   assign if_rs2Address = (ifid_valid_q && uses_rs2) ? ifid_instr_q[24:20] : 5'd0;

endmodule
